// File: rtl/ctrl_spi_tx_if.sv
// ctrl_spi_tx_if: control-frame load bus and SPI pins of ctrl_spi_tx.
// master = the side that supplies the control bytes and pulses start;
// slave  = the SPI transmitter itself.
interface ctrl_spi_tx_if #(
   parameter int BITS = 8
);
   // Handshake: a frame is accepted on any clk edge where start=1 and
   // ready=1; the eight bytes are sampled on that same edge only. start
   // while ready=0 is dropped, never queued. done pulses for one cycle
   // (with ready=1) when the frame and its trailing gap have completed.
   logic            start;
   logic [BITS-1:0] a16;
   logic [BITS-1:0] a8;
   logic [BITS-1:0] a5;
   logic [BITS-1:0] a4;
   logic [BITS-1:0] blend;
   logic [BITS-1:0] delay;
   logic [BITS-1:0] feedbk;
   logic [BITS-1:0] gain;
   logic            ready;
   logic            done;
   logic            ctrl_sclk;
   logic            ctrl_mosi;
   logic            ctrl_ss_n;

   modport master (
      output start, a16, a8, a5, a4, blend, delay, feedbk, gain,
      input  ready, done, ctrl_sclk, ctrl_mosi, ctrl_ss_n
   );

   modport slave (
      input  start, a16, a8, a5, a4, blend, delay, feedbk, gain,
      output ready, done, ctrl_sclk, ctrl_mosi, ctrl_ss_n
   );
endinterface

// File: rtl/ctrl_spi_tx.sv
// ctrl_spi_tx: SPI mode-0 master sending one control frame (a16, a8, a5, a4,
// blend, delay, feedbk, gain; MSB first, byte 0 first) to a_ctrls.
// SS_n stays low for the whole frame; every output is registered.
// Optional macro CTRL_TX_CHKSUM_EN appends a ninth byte holding the sum of
// the eight bytes modulo 2^BITS, captured at latch time.
module ctrl_spi_tx #(
   parameter int BITS     = 8,
   parameter int CLK_DIV  = 25,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int GAP      = 8
) (
   input  logic              clk,
   input  logic              reset,
   ctrl_spi_tx_if.slave      bus,
   output logic [2:0]        state_dbg
);

`ifdef CTRL_TX_CHKSUM_EN
   localparam int NB = 9 * BITS;
`else
   localparam int NB = 8 * BITS;
`endif

   localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_B = (CS_HOLD > GAP) ? CS_HOLD : GAP;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_C + 1);
   localparam int BW    = $clog2(NB + 9);

   // Phase counter reload values: each phase runs (reload + 1) cycles.
   localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   bits_left;
   logic [NB-1:0]   shreg;
   logic [NB-1:0]   frame;

`ifdef CTRL_TX_CHKSUM_EN
   logic [BITS-1:0] chk;

   // Frame image with the modulo-2^BITS checksum byte appended last.
   always_comb begin
      chk   = bus.a16 + bus.a8 + bus.a5 + bus.a4 +
              bus.blend + bus.delay + bus.feedbk + bus.gain;
      frame = {bus.a16, bus.a8, bus.a5, bus.a4,
               bus.blend, bus.delay, bus.feedbk, bus.gain, chk};
   end
`else
   // Frame image: byte 0 (a16) lands in the MSBs so it goes out first.
   always_comb begin
      frame = {bus.a16, bus.a8, bus.a5, bus.a4,
               bus.blend, bus.delay, bus.feedbk, bus.gain};
   end
`endif

   assign state_dbg = state;

   // Frame sequencer: every output changes on the same edge as the state,
   // so MOSI only moves together with a falling SCLK (or before the first rise).
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         bits_left     <= '0;
         shreg         <= '0;
         bus.ready     <= 1'b1;
         bus.done      <= 1'b0;
         bus.ctrl_sclk <= 1'b0;
         bus.ctrl_mosi <= 1'b0;
         bus.ctrl_ss_n <= 1'b1;
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  shreg         <= frame;
                  bus.ctrl_mosi <= frame[NB-1];
                  bus.ctrl_ss_n <= 1'b0;
                  bus.ready     <= 1'b0;
                  bits_left     <= LAST_BIT;
                  cnt           <= SETUP_LD;
                  state         <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == '0) begin
                  cnt   <= HALF_LD;
                  state <= S_LOW;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_LOW: begin
               if (cnt == '0) begin
                  bus.ctrl_sclk <= 1'b1;
                  cnt           <= HALF_LD;
                  state         <= S_HIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_HIGH: begin
               if (cnt == '0) begin
                  bus.ctrl_sclk <= 1'b0;
                  if (bits_left != '0) begin
                     shreg         <= {shreg[NB-2:0], 1'b0};
                     bus.ctrl_mosi <= shreg[NB-2];
                     bits_left     <= bits_left - 1'b1;
                     cnt           <= HALF_LD;
                     state         <= S_LOW;
                  end else begin
                     cnt   <= HOLD_LD;
                     state <= S_HOLD;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  bus.ctrl_ss_n <= 1'b1;
                  bus.ctrl_mosi <= 1'b0;
                  cnt           <= GAP_LD;
                  state         <= S_GAP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (cnt == '0) begin
                  bus.done  <= 1'b1;
                  bus.ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state         <= S_IDLE;
               bus.ready     <= 1'b1;
               bus.ctrl_sclk <= 1'b0;
               bus.ctrl_ss_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_spi_tx.sv
// tb_ctrl_spi_tx: randomized frames for ctrl_spi_tx, checked against a
// frame-level model (byte concatenation, checksum by integer sum, timing
// from the closed-form cycle formulas).
`timescale 1ns/1ps
module tb_ctrl_spi_tx;

   localparam int BITS     = 8;
   localparam int CLK_DIV  = 2;
   localparam int CS_SETUP = 1;
   localparam int CS_HOLD  = 1;
   localparam int GAP      = 2;
`ifdef CTRL_TX_CHKSUM_EN
   localparam int NBYTES = 9;
`else
   localparam int NBYTES = 8;
`endif
   localparam int NB             = NBYTES * BITS;
   localparam int EXP_LAST_LOW   = CS_SETUP + 2 * CLK_DIV * NB + CS_HOLD;
   localparam int EXP_DONE       = EXP_LAST_LOW + GAP + 1;
   localparam int EXP_FIRST_RISE = 1 + CS_SETUP + CLK_DIV;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] state_dbg;

   ctrl_spi_tx_if #(.BITS(BITS)) bus ();

   ctrl_spi_tx #(
      .BITS(BITS), .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP),
      .CS_HOLD(CS_HOLD), .GAP(GAP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [NB-1:0] exp_q[$];
   logic [7:0]    in_b [8];

   int            first_low, last_low, low_cnt, first_rise, rise_cnt;
   int            done_cyc, mosi_bad;
   logic [NB-1:0] cap;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference frame: bytes in order, optional checksum = sum mod 256.
   function automatic logic [NB-1:0] build_word(input logic [7:0] b [8]);
      logic [NB-1:0] w;
      int            sum;
      w   = '0;
      sum = 0;
      for (int i = 0; i < 8; i++) begin
         w   = (w << 8) | NB'(b[i]);
         sum = sum + int'(b[i]);
      end
`ifdef CTRL_TX_CHKSUM_EN
      w = (w << 8) | NB'(sum % 256);
`endif
      return w;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_inputs(input logic [7:0] b [8]);
      bus.a16    = b[0];
      bus.a8     = b[1];
      bus.a5     = b[2];
      bus.a4     = b[3];
      bus.blend  = b[4];
      bus.delay  = b[5];
      bus.feedbk = b[6];
      bus.gain   = b[7];
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 8; i++) in_b[i] = 8'($urandom_range(0, 255));
   endtask

   // Sends in_b as one frame. chained: the current negedge is already the
   // previous frame's done cycle. hold_start keeps start high throughout.
   // noise_at>0 pulses start with other data mid-frame; abort_at>0 resets.
   task automatic run_frame(input bit chained, input bit hold_start,
                            input int noise_at, input int abort_at);
      logic [7:0] nz [8];
      bit         prev_sclk, prev_mosi;
      int         t, late_done, late_low;
      if (!chained) @(negedge clk);
      check("ready_idle", bus.ready, 1);
      drive_inputs(in_b);
      bus.start = 1'b1;
      if (abort_at == 0) exp_q.push_back(build_word(in_b));
      first_low = -1; last_low = -1; low_cnt = 0; first_rise = -1;
      rise_cnt = 0; done_cyc = -1; mosi_bad = 0; cap = '0;
      prev_sclk = 1'b0; prev_mosi = 1'b0;
      t = 0;
      while (t < EXP_DONE + 20) begin
         @(negedge clk);
         t++;
         if (t == 1 && !hold_start) bus.start = 1'b0;
         if (noise_at > 0 && t == noise_at) begin
            for (int i = 0; i < 8; i++) nz[i] = ~in_b[i];
            drive_inputs(nz);
            bus.start = 1'b1;
         end else if (noise_at > 0 && t == noise_at + 1 && !hold_start) begin
            bus.start = 1'b0;
         end
         if (abort_at > 0 && t == abort_at) reset = 1'b1;
         if (abort_at > 0 && t == abort_at + 1) begin
            check("abort_ss_n", bus.ctrl_ss_n, 1);
            check("abort_sclk", bus.ctrl_sclk, 0);
            check("abort_mosi", bus.ctrl_mosi, 0);
            check("abort_ready", bus.ready, 1);
            check("abort_done", bus.done, 0);
            reset = 1'b0;
            break;
         end
         if (!bus.ctrl_ss_n) begin
            if (first_low < 0) first_low = t;
            last_low = t;
            low_cnt++;
         end
         if (bus.ctrl_sclk && !prev_sclk) begin
            rise_cnt++;
            if (first_rise < 0) first_rise = t;
            cap = {cap[NB-2:0], bus.ctrl_mosi};
         end
         if (bus.ctrl_sclk && prev_sclk && bus.ctrl_mosi !== prev_mosi) mosi_bad++;
         prev_sclk = bus.ctrl_sclk;
         prev_mosi = bus.ctrl_mosi;
         if (bus.done) begin
            done_cyc = t;
            break;
         end
      end
      if (abort_at > 0) begin
         late_done = 0;
         late_low  = 0;
         repeat (EXP_DONE) begin
            @(negedge clk);
            if (bus.done) late_done++;
            if (!bus.ctrl_ss_n) late_low++;
         end
         check("abort_no_done", late_done, 0);
         check("abort_idle_ss", late_low, 0);
         return;
      end
      check("first_ss_low", first_low, 1);
      check("last_ss_low", last_low, EXP_LAST_LOW);
      check("ss_low_cnt", low_cnt, EXP_LAST_LOW);
      check("first_rise", first_rise, EXP_FIRST_RISE);
      check("rise_cnt", rise_cnt, NB);
      check("frame_bits", cap, exp_q.pop_front());
      check("mosi_stable", mosi_bad, 0);
      check("done_cycle", done_cyc, EXP_DONE);
      if (!hold_start) begin
         @(negedge clk);
         check("done_single", bus.done, 0);
         check("idle_ss_n", bus.ctrl_ss_n, 1);
         check("idle_ready", bus.ready, 1);
      end
   endtask

   // ---------------- test sequence ----------------
   int last_low_1, done_1;

   initial begin
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) in_b[i] = 8'h00;
      drive_inputs(in_b);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", bus.ready, 1);
      check("rst_done", bus.done, 0);
      check("rst_ss_n", bus.ctrl_ss_n, 1);
      check("rst_sclk", bus.ctrl_sclk, 0);
      check("rst_mosi", bus.ctrl_mosi, 0);
      reset = 1'b0;

      // Fixed pattern with mixed edge bytes.
      in_b = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'h7E, 8'h5A};
      run_frame(0, 0, 0, 0);

      // start with different data mid-frame must be ignored.
      randomize_inputs();
      run_frame(0, 0, 50, 0);

      // Random frames.
      repeat (3) begin
         randomize_inputs();
         run_frame(0, 0, 0, 0);
      end

      // Back-to-back with start held high.
      randomize_inputs();
      run_frame(0, 1, 0, 0);
      last_low_1 = last_low;
      done_1     = done_cyc;
      randomize_inputs();
      run_frame(1, 0, 0, 0);
      check("b2b_ss_high", (done_1 - last_low_1) + (first_low - 1), GAP + 1);

      // Reset mid-frame, then a clean frame.
      randomize_inputs();
      run_frame(0, 0, 0, 100);
      randomize_inputs();
      run_frame(0, 0, 0, 0);

      // Checksum-relevant patterns (plain frames without the macro).
      for (int i = 0; i < 8; i++) in_b[i] = 8'h20;
      run_frame(0, 0, 0, 0);
      in_b = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(0, 0, 0, 0);
      for (int i = 0; i < 8; i++) in_b[i] = 8'hFF;
      run_frame(0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ctrl_spi_tx.md
Name: ctrl_spi_tx

Overview:
- SPI master that sends one control frame to the control receiver `a_ctrls` over CTRL_SCLK / CTRL_MOSI / CTRL_SS_n.
- A frame carries the eight control bytes a16, a8, a5, a4, blend, delay, feedbk, gain.
- Used on the control-panel FPGA that drives the theremin, and as the stimulus generator in the system bench.
- Parallel load with start/ready/done handshake; mode 0, MSB first, SS_n low for the whole frame.

Parameters:
- BITS, 8: width of each control value.
- CLK_DIV, 25: clk cycles per SCLK half-period (1 MHz SCLK at 50 MHz); must be >= 1.
- CS_SETUP, 4: cycles SS_n is low before the first SCLK low phase; must be >= 1.
- CS_HOLD, 4: cycles SS_n stays low after the last SCLK falling edge; must be >= 1.
- GAP, 8: minimum SS_n-high cycles between frames; must be >= 1.

Ports:
- clk  in  1  system clock (clk_50 domain)
- reset  in  1  synchronous, active-high reset
- start  in  1  request to send a frame; accepted only when ready=1
- a16  in  BITS  control value, byte 0 (sent first)
- a8  in  BITS  byte 1
- a5  in  BITS  byte 2
- a4  in  BITS  byte 3
- blend  in  BITS  byte 4
- delay  in  BITS  byte 5
- feedbk  in  BITS  byte 6
- gain  in  BITS  byte 7 (sent last)
- ready  out  1  1 = idle, start will be accepted
- done  out  1  one-cycle pulse when a frame fully completes, including GAP
- ctrl_sclk  out  1  SPI clock, idles low
- ctrl_mosi  out  1  SPI data
- ctrl_ss_n  out  1  SPI select, active low

Behaviour:
- One clock (clk). Reset is synchronous and active-high; all outputs are registered.
- Reset values: ready=1, done=0, ctrl_sclk=0, ctrl_mosi=0, ctrl_ss_n=1, state=IDLE.
- Reset mid-frame aborts the frame: on the next edge SS_n=1 and SCLK=0, no done pulse, and the shift register is cleared.
- Frame length: NB = 8*BITS bits (64 at default). Bits go out MSB first, byte 0 first.
- States: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - ready=1.
  - start=1 in cycle 0 latches all eight inputs into the shift register, sets ready=0 and moves to SETUP.
  - Inputs are sampled only in cycle 0; later changes are ignored.
- SETUP (cycles 1..CS_SETUP): SS_n=0, SCLK=0, MOSI = frame bit NB-1. Then go to LOW.
- LOW (CLK_DIV cycles): SCLK=0, MOSI holds the current bit. Then go to HIGH.
- HIGH (CLK_DIV cycles): SCLK=1.
  - On exit, if bits remain: shift, MOSI takes the next bit on the same edge that SCLK falls, go to LOW.
  - Otherwise go to HOLD with SCLK=0.
- HOLD (CS_HOLD cycles): SS_n=0, SCLK=0. Then SS_n=1 and go to GAP.
- GAP (GAP cycles): SS_n=1, MOSI=0.
  - On exit: done=1 for exactly one cycle, ready=1 in that same cycle, state=IDLE.
  - start in the done cycle is accepted (back-to-back frames).
- The receiver samples on SCLK rising. MOSI never changes while SCLK=1.
- Timing (cycle 0 = start accepted):
  - First SCLK rise at cycle 1+CS_SETUP+CLK_DIV.
  - SS_n low for cycles 1 .. CS_SETUP + 2*CLK_DIV*NB + CS_HOLD.
  - done at cycle 1 + CS_SETUP + 2*CLK_DIV*NB + CS_HOLD + GAP.
  - Default: SS_n low for cycles 1..3208, done at cycle 3217.
- start while ready=0 is ignored; no queuing.
- Counters: one half-period/phase counter of width clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, GAP)+1), and one bit counter of width clog2(NB+9).

Optional Feature:
- Macro: CTRL_TX_CHKSUM_EN.
- Defined: a ninth byte is appended after gain. It is the sum of the eight bytes modulo 2^BITS, computed at latch time. NB becomes 9*BITS and all timing formulas use the new NB.
- Undefined: frame is exactly 8*BITS bits, with no checksum logic.

Test Plan:
- Reset values. Assert reset 3 cycles -> ready=1, done=0, ctrl_ss_n=1, ctrl_sclk=0, ctrl_mosi=0.
- Basic frame with CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, GAP=2. Inputs a16=0xA5, a8=0x01, a5=0x80, a4=0xFF, blend=0x00, delay=0x3C, feedbk=0x7E, gain=0x5A, start pulse.
  - SS_n low cycles 1..258, first SCLK rise at cycle 4, 64 rises.
  - Bits captured on rising edges = 0xA50180FF003C7E5A.
  - done at cycle 261.
- Ignored start: pulse start at cycle 50 of an active frame with different inputs -> frame unchanged, single done pulse.
- Back-to-back: hold start=1 continuously -> second frame begins the cycle after done. SS_n-high stretch is exactly GAP+1=3 cycles (last GAP cycle, done/accept cycle, then SS_n low).
- Reset mid-frame: assert reset at cycle 100 -> next edge SS_n=1, SCLK=0, ready=1. No done pulse. A following start sends a complete, correct frame.
- CTRL_TX_CHKSUM_EN defined, inputs all 0x20 -> 72 bits sent, last byte 0x00 (0x100 mod 256). With a16=0x01 and the rest 0 -> last byte 0x01, done at cycle 1+1+288+1+2=293.
